multi_delay_timer: RTL and testbench

- Multi-channel, retriggerable inactivity timer.
- Each channel raises a one-cycle expiry pulse a programmable number of clocks after its trigger input last fell.
- Generalises the transmitter's single fixed 1 s delayer: parametrised channel count and counter width, run-time reloadable delay, and one-shot or auto-reload mode per channel.
- Sits between control FSMs and the transmitter; used for inter-frame gaps, watchdogs and periodic ticks.

---
 rtl/multi_delay_timer_pkg.sv | 13 +
 rtl/delay_channel.sv | 90 +++++++++
 rtl/multi_delay_timer.sv | 49 ++++
 tb/tb_multi_delay_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_delay_timer_pkg.sv
// Shared types and constants for the multi-channel inactivity timer.
package multi_delay_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_COUNTING = 2'd2
  } ch_state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/delay_channel.sv
// One retriggerable timer channel: FSM, counter, delay register, registered outputs.
// Optional cancel input is present when MULTI_DELAY_TIMER_CANCEL_EN is defined.
module delay_channel
  import multi_delay_timer_pkg::*;
#(
  parameter int CNT_W         = 26,
  parameter int DEFAULT_DELAY = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             mode,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
`ifdef MULTI_DELAY_TIMER_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             expired,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DEF_DELAY = CNT_W'(DEFAULT_DELAY);

  ch_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, delay_reg;
  logic [CNT_W:0]   cnt_inc;
  logic             expired_nxt;
  logic             hit;

  // The falling-edge sample already counts as the first cycle, so ARMED with
  // trig low runs the same compare as COUNTING. Using >= lets a shrunk delay
  // expire on the next edge instead of wrapping.
  assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign hit     = cnt_inc >= {1'b0, delay_reg};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    cnt_nxt     = cnt;
    expired_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig) state_nxt = ST_ARMED;
      end
      ST_ARMED, ST_COUNTING: begin
        if (trig) begin
          state_nxt = ST_ARMED;
          cnt_nxt   = '0;
        end else if (hit) begin
          expired_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = (mode == MODE_RELOAD) ? ST_COUNTING : ST_IDLE;
        end else begin
          state_nxt = ST_COUNTING;
          cnt_nxt   = cnt_inc[CNT_W-1:0];
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
`ifdef MULTI_DELAY_TIMER_CANCEL_EN
    if (cancel) begin
      state_nxt   = ST_IDLE;
      cnt_nxt     = '0;
      expired_nxt = 1'b0;
    end
`endif
  end

  // NOTE: state flops use non-blocking assignments so all channels update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      expired   <= 1'b0;
      busy      <= 1'b0;
      // NOTE: the delay register is real state and must return to its default on reset.
      delay_reg <= DEF_DELAY;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      expired <= expired_nxt;
      busy    <= (state_nxt != ST_IDLE);
      if (load) delay_reg <= (load_val == '0) ? CNT_W'(1) : load_val;
    end
  end

endmodule

// File: rtl/multi_delay_timer.sv
// Multi-channel retriggerable inactivity timer; decodes the delay load strobe per channel.
// Define MULTI_DELAY_TIMER_CANCEL_EN to add the per-channel cancel input.
module multi_delay_timer
  import multi_delay_timer_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 26,
  parameter int DEFAULT_DELAY = 50000000,
  parameter int CH_IDX_W      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   trig,
  input  logic [NUM_CH-1:0]   mode,
  input  logic                load_en,
  input  logic [CH_IDX_W-1:0] load_ch,
  input  logic [CNT_W-1:0]    load_val,
`ifdef MULTI_DELAY_TIMER_CANCEL_EN
  input  logic [NUM_CH-1:0]   cancel,
`endif
  output logic [NUM_CH-1:0]   expired,
  output logic [NUM_CH-1:0]   busy
);

  logic [NUM_CH-1:0] load_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range indices match no channel, so such loads are dropped.
    assign load_sel[i] = load_en && (load_ch == CH_IDX_W'(i));

    delay_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_DELAY(DEFAULT_DELAY)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .trig    (trig[i]),
      .mode    (mode[i]),
      .load    (load_sel[i]),
      .load_val(load_val),
`ifdef MULTI_DELAY_TIMER_CANCEL_EN
      .cancel  (cancel[i]),
`endif
      .expired (expired[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Scoreboard bench for multi_delay_timer: directed scenarios then random traffic
// against an absolute-time reference model. Honours MULTI_DELAY_TIMER_CANCEL_EN.
module tb_multi_delay_timer;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 8;
  localparam int DEF      = 10;
  localparam int CH_IDX_W = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM_CH-1:0]   trig, mode, cancel;
  logic                load_en;
  logic [CH_IDX_W-1:0] load_ch;
  logic [CNT_W-1:0]    load_val;
  logic [NUM_CH-1:0]   expired, busy;

  always #5 clk = ~clk;

  multi_delay_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DELAY(DEF), .CH_IDX_W(CH_IDX_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .trig    (trig),
    .mode    (mode),
    .load_en (load_en),
    .load_ch (load_ch),
    .load_val(load_val),
`ifdef MULTI_DELAY_TIMER_CANCEL_EN
    .cancel  (cancel),
`endif
    .expired (expired),
    .busy    (busy)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] expired;
    logic [NUM_CH-1:0] busy;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    tests = 0;
  int    fails = 0;
  int    dut_pulses[NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Reference model: a running channel remembers the cycle its count began and
  // expires once the elapsed cycles (inclusive) reach its delay.
  typedef enum {M_IDLE, M_ARMED, M_RUN} mphase_e;
  mphase_e ph[NUM_CH];
  int      start_cyc[NUM_CH];
  int      dly[NUM_CH];
  int      cyc = 0;

  function automatic resp_t model_step();
    resp_t r;
    logic [NUM_CH-1:0] cx;
    r  = '0;
    cx = '0;
`ifdef MULTI_DELAY_TIMER_CANCEL_EN
    cx = cancel;
`endif
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ph[i]  = M_IDLE;
        dly[i] = DEF;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cx[i]) ph[i] = M_IDLE;
        else if (trig[i]) ph[i] = M_ARMED;
        else if (ph[i] != M_IDLE) begin
          if (ph[i] == M_ARMED) begin
            ph[i]        = M_RUN;
            start_cyc[i] = cyc;
          end
          if (cyc - start_cyc[i] + 1 >= dly[i]) begin
            r.expired[i] = 1'b1;
            if (mode[i]) start_cyc[i] = cyc + 1;
            else ph[i] = M_IDLE;
          end
        end
        r.busy[i] = (ph[i] != M_IDLE);
      end
      if (load_en && int'(load_ch) < NUM_CH)
        dly[load_ch] = (load_val == '0) ? 1 : int'(load_val);
    end
    cyc++;
    return r;
  endfunction

  // Inputs are set by the caller just after a falling edge; one tick covers one rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_step());
      @(negedge clk);
    end
  endtask

  initial begin : monitor
    for (int i = 0; i < NUM_CH; i++) dut_pulses[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("expired", 32'(expired), 32'(mon_e.expired));
        check("busy", 32'(busy), 32'(mon_e.busy));
      end
      for (int i = 0; i < NUM_CH; i++) if (expired[i] === 1'b1) dut_pulses[i]++;
    end
  end

  initial begin : stimulus
    int base;
    // NOTE: inputs are driven with blocking assignments from this process, clear of the rising edge.
    reset    = 1'b0;
    trig     = '1;
    mode     = '0;
    cancel   = '0;
    load_en  = 1'b0;
    load_ch  = '0;
    load_val = '0;
    @(negedge clk);

    tick(3);
    check("reset_expired", 32'(expired), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    tick(1);
    check("armed_after_reset", 32'(busy), 32'hF);

    // One-shot on ch0 (all channels fall together).
    tick(1);
    base = dut_pulses[0];
    trig = '0;
    tick(9);
    check("oneshot_early", 32'(expired[0]), 32'h0);
    tick(1);
    check("oneshot_pulse", 32'(expired[0]), 32'h1);
    check("oneshot_busy_drop", 32'(busy[0]), 32'h0);
    tick(5);
    check("oneshot_count", 32'(dut_pulses[0] - base), 32'd1);

    // Retrigger ch1.
    trig[1] = 1'b1; tick(2);
    base = dut_pulses[1];
    trig[1] = 1'b0; tick(6);
    trig[1] = 1'b1; tick(1);
    trig[1] = 1'b0; tick(9);
    check("retrig_no_early", 32'(dut_pulses[1] - base), 32'd0);
    tick(1);
    check("retrig_pulse", 32'(expired[1]), 32'h1);
    tick(3);

    // Auto-reload ch2.
    mode[2] = 1'b1;
    trig[2] = 1'b1; tick(1);
    base = dut_pulses[2];
    trig[2] = 1'b0; tick(40);
    trig[2] = 1'b1; tick(5);
    check("reload_count", 32'(dut_pulses[2] - base), 32'd4);
    check("reload_held_busy", 32'(busy[2]), 32'h1);
    trig[2] = 1'b0; mode[2] = 1'b0;
    tick(12);

    // Load mid-count on ch3, then a zero load.
    trig[3] = 1'b1; tick(1);
    trig[3] = 1'b0; tick(7);
    load_en = 1'b1; load_ch = 3'd3; load_val = 8'd5; tick(1);
    load_en = 1'b0;
    check("load_no_pulse_yet", 32'(expired[3]), 32'h0);
    tick(1);
    check("load_shrink_pulse", 32'(expired[3]), 32'h1);
    load_en = 1'b1; load_val = 8'd0; tick(1);
    load_ch = 3'd5; load_val = 8'd3; tick(1);
    load_en = 1'b0;
    trig[3] = 1'b1; tick(1);
    trig[3] = 1'b0; tick(1);
    check("delay_one_pulse", 32'(expired[3]), 32'h1);
    tick(2);

    // Reset mid-count restores the default delays.
    trig[0] = 1'b1; tick(1);
    trig[0] = 1'b0; tick(5);
    reset = 1'b0; tick(1);
    check("midreset_expired", 32'(expired), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    trig[3] = 1'b1; tick(1);
    trig[3] = 1'b0; tick(9);
    check("default_back_early", 32'(expired[3]), 32'h0);
    tick(1);
    check("default_back_pulse", 32'(expired[3]), 32'h1);
    tick(2);

`ifdef MULTI_DELAY_TIMER_CANCEL_EN
    trig[0] = 1'b1; tick(1);
    trig[0] = 1'b0; tick(9);
    cancel[0] = 1'b1; tick(1);
    cancel[0] = 1'b0;
    check("cancel_no_pulse", 32'(expired[0]), 32'h0);
    check("cancel_idle", 32'(busy[0]), 32'h0);
    tick(3);
`endif

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 7) == 0) trig[i] = ~trig[i];
        if ($urandom_range(0, 15) == 0) mode[i] = ~mode[i];
`ifdef MULTI_DELAY_TIMER_CANCEL_EN
        cancel[i] = ($urandom_range(0, 31) == 0);
`endif
      end
      load_en  = ($urandom_range(0, 19) == 0);
      load_ch  = CH_IDX_W'($urandom_range(0, 5));
      load_val = CNT_W'($urandom_range(0, 25));
      reset    = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    reset = 1'b1; load_en = 1'b0; cancel = '0;
    tick(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
